serial_add_ctrl: RTL and testbench
==================================

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 SHALL have parameter: WIDTH, default 8, operand width in bits; legal range 2..32.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port: start  input  1  request to begin one addition.
REQ-005 SHALL have port: a  input  WIDTH  operand A, sampled only when start is accepted.
REQ-006 SHALL have port: b  input  WIDTH  operand B, sampled only when start is accepted.
REQ-007 SHALL have port: cin  input  1  carry-in, sampled only when start is accepted.
REQ-008 SHALL have port: busy  output  1  high while bits are being processed.
REQ-009 SHALL have port: done  output  1  one-cycle pulse when the result is valid.
REQ-010 SHALL have port: sum  output  WIDTH  registered result of the last completed addition.
REQ-011 SHALL have port: cout  output  1  registered carry-out of the last completed addition.

Function
REQ-012 SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-013 SHALL accept start only in IDLE or DONE; on acceptance it latches a, b and cin, clears the bit counter, and enters RUN.
REQ-014 SHALL ignore start in RUN, leaving operands, counter and outputs undisturbed.
REQ-015 SHALL compute exactly one bit per RUN cycle, LSB first, using a single 1-bit full-adder cell fed by the operand shift-register LSBs and a carry flip-flop.
REQ-016 SHALL shift A and B right, shift the sum bit into the MSB of a partial-sum register, and load the carry flip-flop with the cell's carry-out in every RUN cycle.
REQ-017 SHALL stay in RUN for exactly WIDTH cycles, tracked by a $clog2(WIDTH)-bit counter, then enter DONE.
REQ-018 SHALL have fixed latency: if start is accepted at edge T, busy=1 for the cycles after edges T..T+WIDTH-1 and done=1 for exactly the cycle after edge T+WIDTH.
REQ-019 SHALL update sum and cout only on the RUN->DONE transition, holding them until the next completion or reset.
REQ-020 SHALL implement the arithmetic {cout,sum} = a + b + cin modulo 2^(WIDTH+1), with no overflow flag.
REQ-021 SHALL go DONE->IDLE when start=0, and DONE->RUN when start=1 (back-to-back operation with no idle gap).
REQ-022 SHALL keep busy and done mutually exclusive in every cycle.

Reset
REQ-023 SHALL, when rst=1 at a clock edge, set state=IDLE, busy=0, done=0, sum=0, cout=0, carry flip-flop=0 and counter=0, regardless of state.
REQ-024 SHALL give rst priority over start in the same cycle.
REQ-025 SHALL, when reset is applied mid-RUN, discard the operation entirely: no done pulse and no sum/cout update.

Structure
REQ-026 SHALL place the FSM state encoding (IDLE=2'b00, RUN=2'b01, DONE=2'b10) and the default WIDTH constant in a shared package, serial_add_pkg.
REQ-027 SHALL instantiate exactly one sub-module, fa_cell (a purely combinational 1-bit full adder: in_0, in_1, cin -> out, cout), with all sequencing kept in serial_add_ctrl.

Verification
REQ-028 SHALL be verified with WIDTH=8, a=0x5A, b=0x3C, cin=0, start pulsed in IDLE -> busy for 8 cycles, done on the 9th cycle, sum=0x96, cout=0.
REQ-029 SHALL be verified with a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; and a=0xFF, b=0x00, cin=1 -> sum=0x00, cout=1.
REQ-030 SHALL be verified with a=0x12, b=0x34 accepted, then start re-asserted with a=0xAA, b=0xAA during RUN cycle 3 -> ignored; result sum=0x46, cout=0.
REQ-031 SHALL be verified with rst asserted in RUN cycle 4 of a=0x80, b=0x80 -> next cycle busy=0, done=0, sum=0x00, cout=0, and no done pulse afterwards.
REQ-032 SHALL be verified with start held high through the DONE cycle of 0x01+0x01 while a=0x0F, b=0xF0 -> first done gives sum=0x02; RUN resumes immediately; second done, 9 cycles later, gives sum=0xFF, cout=0.
REQ-033 SHALL be verified with rst and start both high in the same cycle -> state IDLE, busy stays 0.

Source files
------------

// File: rtl/serial_add_pkg.sv
// serial_add_pkg: shared FSM state encoding and default operand width
package serial_add_pkg;
   localparam int DEFAULT_WIDTH = 8;
   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_t;
endpackage

// File: rtl/fa_cell.sv
// fa_cell: combinational 1-bit full adder
module fa_cell (
   input  logic in_0,
   input  logic in_1,
   input  logic cin,
   output logic out,
   output logic cout
);
   always_comb begin
      out  = in_0 ^ in_1 ^ cin;
      cout = (in_0 & in_1) | (cin & (in_0 ^ in_1));
   end
endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder, one bit per cycle LSB first, fixed WIDTH-cycle latency
module serial_add_ctrl
   import serial_add_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);
   localparam int CW = $clog2(WIDTH);
   state_t           r_state;
   logic [WIDTH-1:0] r_a, r_b, r_psum, r_sum;
   logic [CW-1:0]    r_cnt;
   logic             r_carry, r_busy, r_done, r_cout;
   logic             w_s, w_co, w_last;
   logic [WIDTH-1:0] w_psum;
   fa_cell u_fa (
      .in_0 (r_a[0]),
      .in_1 (r_b[0]),
      .cin  (r_carry),
      .out  (w_s),
      .cout (w_co)
   );
   // new sum bit enters at the MSB so the first bit lands at the LSB after WIDTH shifts
   always_comb begin
      w_psum = (r_psum >> 1) | (WIDTH'(w_s) << (WIDTH - 1));
      w_last = r_cnt == CW'(WIDTH - 1);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_sum   <= '0;
         r_cout  <= 1'b0;
         r_carry <= 1'b0;
         r_cnt   <= '0;
         r_a     <= '0;
         r_b     <= '0;
         r_psum  <= '0;
      end else begin
         case (r_state)
            RUN: begin
               r_a     <= r_a >> 1;
               r_b     <= r_b >> 1;
               r_psum  <= w_psum;
               r_carry <= w_co;
               r_cnt   <= r_cnt + 1'b1;
               if (w_last) begin
                  r_state <= DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_sum   <= w_psum;
                  r_cout  <= w_co;
               end
            end
            // IDLE, DONE and the unused encoding all accept a new start
            default: begin
               r_done <= 1'b0;
               if (start) begin
                  r_state <= RUN;
                  r_busy  <= 1'b1;
                  r_a     <= a;
                  r_b     <= b;
                  r_carry <= cin;
                  r_cnt   <= '0;
                  r_psum  <= '0;
               end else begin
                  r_state <= IDLE;
               end
            end
         endcase
      end
   end
   always_comb begin
      busy = r_busy;
      done = r_done;
      sum  = r_sum;
      cout = r_cout;
   end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: scoreboard-based self-checking bench for serial_add_ctrl
module tb_serial_add_ctrl;
   localparam int W = 8;
   logic         clk = 1'b0;
   logic         rst, start, cin, busy, done, cout;
   logic [W-1:0] a, b, sum;
   logic [W:0]   exp_q[$];
   logic [W:0]   exp_v;
   int           n_checks = 0;
   int           n_fail = 0;
   int           bc, excl;
   bit           ok;

   serial_add_ctrl #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
      return {1'b0, x} + {1'b0, y} + (W+1)'(c);
   endfunction

   task automatic launch(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
      a = x;
      b = y;
      cin = c;
      start = 1'b1;
      exp_q.push_back(model(x, y, c));
      tick();
      start = 1'b0;
   endtask

   // counts busy cycles and busy/done overlaps until done appears or the budget expires
   task automatic wait_done(output int busy_cnt, output int overlap, output bit seen);
      busy_cnt = 0;
      overlap = 0;
      seen = 1'b0;
      for (int i = 0; i < W + 4; i++) begin
         if (busy && done) overlap++;
         if (done) begin
            seen = 1'b1;
            break;
         end
         if (busy) busy_cnt++;
         tick();
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      start = 1'b0;
      a = '0;
      b = '0;
      cin = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
      n_checks++; if (sum !== 8'h00) begin n_fail++; $display("FAIL reset_sum: got %h expected 00", sum); end
      n_checks++; if (cout !== 1'b0) begin n_fail++; $display("FAIL reset_cout: got %b expected 0", cout); end
   endtask

   task automatic test_basic();
      launch(8'h5A, 8'h3C, 1'b0);
      wait_done(bc, excl, ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL basic_done: got no done expected done within %0d cycles", W + 4); end
      n_checks++; if (bc !== W) begin n_fail++; $display("FAIL basic_latency: got %0d busy cycles expected %0d", bc, W); end
      n_checks++; if (excl !== 0) begin n_fail++; $display("FAIL basic_excl: got %0d overlaps expected 0", excl); end
      exp_v = exp_q.pop_front();
      n_checks++; if (exp_v !== 9'h096) begin n_fail++; $display("FAIL basic_model: got %h expected 096", exp_v); end
      n_checks++; if ({cout, sum} !== exp_v) begin n_fail++; $display("FAIL basic_result: got %h expected %h", {cout, sum}, exp_v); end
      tick();
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL basic_pulse: got done=%b expected 0", done); end
      n_checks++; if ({cout, sum} !== exp_v) begin n_fail++; $display("FAIL basic_hold: got %h expected %h", {cout, sum}, exp_v); end
   endtask

   task automatic test_carry();
      launch(8'hFF, 8'h01, 1'b0);
      wait_done(bc, excl, ok);
      exp_v = exp_q.pop_front();
      n_checks++; if (!ok || {cout, sum} !== exp_v) begin n_fail++; $display("FAIL carry_ff01: got %h expected %h", {cout, sum}, exp_v); end
      tick();
      launch(8'hFF, 8'h00, 1'b1);
      wait_done(bc, excl, ok);
      exp_v = exp_q.pop_front();
      n_checks++; if (!ok || {cout, sum} !== 9'h100) begin n_fail++; $display("FAIL carry_ff00c: got %h expected 100", {cout, sum}); end
      tick();
   endtask

   task automatic test_ignore_start();
      launch(8'h12, 8'h34, 1'b0);
      tick();
      tick();
      a = 8'hAA;
      b = 8'hAA;
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_done(bc, excl, ok);
      exp_v = exp_q.pop_front();
      n_checks++; if (!ok || bc !== 5) begin n_fail++; $display("FAIL ignore_latency: got %0d busy cycles expected 5", bc); end
      n_checks++; if ({cout, sum} !== exp_v) begin n_fail++; $display("FAIL ignore_result: got %h expected %h", {cout, sum}, exp_v); end
      tick();
      n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL ignore_after: got busy=%b done=%b expected 0 0", busy, done); end
   endtask

   task automatic test_mid_run_reset();
      int dones = 0;
      a = 8'h80;
      b = 8'h80;
      cin = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL midrst_flags: got busy=%b done=%b expected 0 0", busy, done); end
      n_checks++; if ({cout, sum} !== 9'h000) begin n_fail++; $display("FAIL midrst_result: got %h expected 000", {cout, sum}); end
      for (int i = 0; i < W + 4; i++) begin
         if (done || busy) dones++;
         tick();
      end
      n_checks++; if (dones !== 0) begin n_fail++; $display("FAIL midrst_quiet: got %0d active cycles expected 0", dones); end
   endtask

   task automatic test_back_to_back();
      a = 8'h01;
      b = 8'h01;
      cin = 1'b0;
      start = 1'b1;
      exp_q.push_back(model(8'h01, 8'h01, 1'b0));
      tick();
      a = 8'h0F;
      b = 8'hF0;
      exp_q.push_back(model(8'h0F, 8'hF0, 1'b0));
      wait_done(bc, excl, ok);
      exp_v = exp_q.pop_front();
      n_checks++; if (!ok || {cout, sum} !== exp_v) begin n_fail++; $display("FAIL b2b_first: got %h expected %h", {cout, sum}, exp_v); end
      tick();
      start = 1'b0;
      n_checks++; if (busy !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL b2b_resume: got busy=%b done=%b expected 1 0", busy, done); end
      wait_done(bc, excl, ok);
      exp_v = exp_q.pop_front();
      n_checks++; if (!ok || bc !== W) begin n_fail++; $display("FAIL b2b_latency: got %0d busy cycles expected %0d", bc, W); end
      n_checks++; if ({cout, sum} !== 9'h0FF || exp_v !== 9'h0FF) begin n_fail++; $display("FAIL b2b_second: got %h expected %h", {cout, sum}, exp_v); end
      tick();
   endtask

   task automatic test_rst_start();
      rst = 1'b1;
      start = 1'b1;
      a = 8'h11;
      b = 8'h22;
      tick();
      rst = 1'b0;
      start = 1'b0;
      n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL rststart_now: got busy=%b done=%b expected 0 0", busy, done); end
      tick();
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rststart_later: got busy=%b expected 0", busy); end
   endtask

   task automatic test_random();
      for (int i = 0; i < 8; i++) begin
         launch(W'($urandom), W'($urandom), 1'($urandom));
         wait_done(bc, excl, ok);
         exp_v = exp_q.pop_front();
         n_checks++; if (!ok || bc !== W || excl !== 0) begin n_fail++; $display("FAIL random_timing_%0d: got busy=%0d overlap=%0d expected %0d 0", i, bc, excl, W); end
         n_checks++; if ({cout, sum} !== exp_v) begin n_fail++; $display("FAIL random_result_%0d: got %h expected %h", i, {cout, sum}, exp_v); end
         if (i[0]) tick();
      end
      tick();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_carry();
      test_ignore_start();
      test_mid_run_reset();
      test_back_to_back();
      test_rst_start();
      test_random();
      n_checks++; if (exp_q.size() !== 0) begin n_fail++; $display("FAIL scoreboard_empty: got %0d left expected 0", exp_q.size()); end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
